decode_stage: RTL and testbench

Parametrised ID stage for the pipelined RISC-V core: it decodes one instruction per cycle, generates the XLEN-wide immediate and registers the decoded fields into the ID/EX pipeline register. It sits between the fetch stage and `Execute`, and replaces the fixed 32-bit decode/hazard pair with valid/ready handshakes on both sides. It also contains an integrated load-use interlock and a saturating stall counter.

---
 rtl/decode_stage_pkg.sv | 55 +++++
 rtl/decode_stage_if.sv | 40 ++++
 rtl/decode_stage_imm_gen.sv | 72 +++++++
 rtl/decode_stage.sv | 108 ++++++++++
 tb/tb_decode_stage.sv | 391 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// rv_pkg: shared RISC-V decode definitions (opcodes, shift funct3 codes,
// immediate format enum and the packed decoded-field record).
// Ports: none (package).
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // funct3 codes that turn OP-IMM into a shift-by-immediate
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

  // XLEN-independent part of the ID/EX register
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rd_we;
    logic       is_load;
    logic       illegal;
  } dec_t;

  function automatic logic fmt_uses_rs1(input fmt_e f);
    return (f == FMT_R) || (f == FMT_I) || (f == FMT_S) || (f == FMT_B);
  endfunction

  function automatic logic fmt_uses_rs2(input fmt_e f);
    return (f == FMT_R) || (f == FMT_S) || (f == FMT_B);
  endfunction

  function automatic logic fmt_writes_rd(input fmt_e f);
    return (f == FMT_R) || (f == FMT_I) || (f == FMT_U) || (f == FMT_J);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch->ID valid/ready channel plus the ID/EX register
// outputs and the EX-side ready. master = surrounding pipeline, slave = stage.
// Ports: none (signals grouped below, XLEN-parameterised PC and immediate).
interface decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  // execute side
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_is_load;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_rd_we, out_is_load,
           out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_opcode, out_funct3,
           out_funct7, out_rs1, out_rs2, out_rd, out_rd_we, out_is_load,
           out_illegal
  );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational immediate generator and format classifier.
// Ports: instr (32-bit word) -> imm (XLEN, sign/zero-extended), fmt, illegal.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen: XLEN must be 32 or 64");
  end

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Every format fits in 32 bits with instr[31] as its sign (shift amounts are
  // zero-extended so their bit 31 is 0); widening to XLEN is a plain sign fill.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_X;
    illegal = 1'b0;
    case (opcode)
      OP_REG: fmt = FMT_R;
      OP_IMM: begin
        fmt = FMT_I;
        if (funct3 == F3_SLL || funct3 == F3_SR) begin
          // shamt only; funct7 bits above it must not leak into the immediate
          if (XLEN == 64) imm32 = {26'b0, instr[25:20]};
          else            imm32 = {27'b0, instr[24:20]};
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_LOAD, OP_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RISC-V ID stage - decode, immediate generation, ID/EX register,
// load-use interlock and saturating bubble counter.
// Ports: clk, reset (async, active-high), flush, bus (decode_stage_if.slave), stall_cnt.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit HAZARD_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  decode_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  dec_t            d;
  dec_t            q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic            valid_q;
  logic            rs1_used;
  logic            rs2_used;
  logic            load_use;
  logic            in_rdy;
  logic            accept;
  logic            bubble;

  assign rs1_used = fmt_uses_rs1(dec_fmt);
  assign rs2_used = fmt_uses_rs2(dec_fmt);

  always_comb begin
    d         = '0;
    d.opcode  = bus.in_instr[6:0];
    d.funct3  = bus.in_instr[14:12];
    d.funct7  = bus.in_instr[31:25];
    d.rs1     = bus.in_instr[19:15];
    d.rs2     = bus.in_instr[24:20];
    d.rd      = bus.in_instr[11:7];
    d.rd_we   = fmt_writes_rd(dec_fmt) && (bus.in_instr[11:7] != 5'd0);
    d.is_load = (bus.in_instr[6:0] == OP_LOAD);
    d.illegal = dec_illegal;
  end

  // Load in ID/EX whose destination is a source of the incoming instruction.
  // q.rd_we already excludes x0, so a load to x0 never interlocks.
  assign load_use = HAZARD_EN && valid_q && q.is_load && q.rd_we && bus.in_valid &&
                    ((rs1_used && (d.rs1 == q.rd)) || (rs2_used && (d.rs2 == q.rd)));

  assign in_rdy = (!valid_q || bus.out_ready) && !load_use && !flush;
  assign accept = bus.in_valid && in_rdy;
  // a bubble is only counted when the load actually leaves for EX unflushed
  assign bubble = load_use && bus.out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      q       <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      q       <= d;
      pc_q    <= bus.in_pc;
      imm_q   <= dec_imm;
    end else if (bus.out_ready) begin
      // consumed with nothing new behind it (includes the load-use bubble)
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bubble && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_opcode  = q.opcode;
  assign bus.out_funct3  = q.funct3;
  assign bus.out_funct7  = q.funct7;
  assign bus.out_rs1     = q.rs1;
  assign bus.out_rs2     = q.rs2;
  assign bus.out_rd      = q.rd;
  assign bus.out_rd_we   = q.rd_we;
  assign bus.out_is_load = q.is_load;
  assign bus.out_illegal = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with three instances
// (XLEN=32 interlocked, XLEN=64, XLEN=32 without interlock).
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        flush32, flush64, flushnh;
  logic [15:0] cnt32, cnt64, cntnh;

  decode_stage_if #(.XLEN(32)) bus32 ();
  decode_stage_if #(.XLEN(64)) bus64 ();
  decode_stage_if #(.XLEN(32)) busnh ();

  decode_stage #(.XLEN(32), .HAZARD_EN(1'b1), .CNT_W(16)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush32), .bus(bus32), .stall_cnt(cnt32));
  decode_stage #(.XLEN(64), .HAZARD_EN(1'b1), .CNT_W(16)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush64), .bus(bus64), .stall_cnt(cnt64));
  decode_stage #(.XLEN(32), .HAZARD_EN(1'b0), .CNT_W(16)) u_dutnh (
    .clk(clk), .reset(reset), .flush(flushnh), .bus(busnh), .stall_cnt(cntnh));

  typedef struct {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic        illegal;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt32 = '0;

  localparam logic [31:0] I_LW     = 32'h0000A183; // lw  x3,0(x1)
  localparam logic [31:0] I_ADD    = 32'h00118233; // add x4,x3,x1
  localparam logic [31:0] I_LW0    = 32'h0000A003; // lw  x0,0(x1)
  localparam logic [31:0] I_ADD0   = 32'h00100233; // add x4,x0,x1
  localparam logic [31:0] I_ADDI_M = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] I_AUIPC  = 32'h12345297; // auipc x5,0x12345

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [63:0] pc, input logic [63:0] imm, input logic [4:0] rd,
                              input logic we, input logic ld, input logic il);
    exp_t e;
    e.pc = pc; e.imm = imm; e.rd = rd; e.rd_we = we; e.is_load = ld; e.illegal = il;
    return e;
  endfunction

  // Present one instruction on the 32-bit instance until it is taken (bounded).
  task automatic drive32(input logic [31:0] pc, input logic [31:0] instr, output bit ok);
    bus32.in_valid = 1'b1;
    bus32.in_pc    = pc;
    bus32.in_instr = instr;
    ok = 1'b0;
    #1;
    for (int n = 0; n < 20; n++) begin
      if (bus32.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    bus32.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    flush32 = 1'b0; flush64 = 1'b0; flushnh = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_pc = '0; bus32.in_instr = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_pc = '0; bus64.in_instr = '0; bus64.out_ready = 1'b1;
    busnh.in_valid = 1'b0; busnh.in_pc = '0; busnh.in_instr = '0; busnh.out_ready = 1'b1;
    #1 reset = 1'b1;
    #1;
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd, bus32.out_rd_we, cnt32} !== '0) begin
      fails++;
      $display("FAIL reset32: got valid=%b pc=%h imm=%h rd=%0d cnt=%0d expected all zero",
               bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd, cnt32);
    end
    tests++;
    if ({bus64.out_valid, bus64.out_imm, cnt64, busnh.out_valid, cntnh} !== '0) begin
      fails++;
      $display("FAIL reset64_nh: got v64=%b imm64=%h cnt64=%0d vnh=%b cntnh=%0d expected zeros",
               bus64.out_valid, bus64.out_imm, cnt64, busnh.out_valid, cntnh);
    end
    tests++;
    if (bus32.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_imm();
    logic [31:0] ins [11];
    logic [31:0] imms [11];
    logic [4:0]  rds [11];
    logic [10:0] wes, lds, ils;
    bit ok;
    exp_t e;
    ins  = '{32'hFFF00093, 32'h00509113, 32'hFFF09103, 32'h001000EF, 32'hFE20AE23, 32'hFE000FE3,
             32'h4030D093, 32'h0000007F, 32'h00000073, 32'h00208033, I_AUIPC};
    imms = '{32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h800, 32'hFFFFFFFC, 32'hFFFFFFFE,
             32'h3, 32'h0, 32'h0, 32'h0, 32'h12345000};
    rds  = '{5'd1, 5'd2, 5'd2, 5'd1, 5'd28, 5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 5'd5};
    // bit i corresponds to table entry i
    wes  = 11'b100_0100_1111;
    lds  = 11'b000_0000_0100;
    ils  = 11'b001_1000_0000;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sb.push_back(mk(64'h1000 + 64'(4 * i), {32'h0, imms[i]}, rds[i], wes[i], lds[i], ils[i]));
      drive32(32'h1000 + 32'(4 * i), ins[i], ok);
      tests++;
      if (!ok || bus32.out_valid !== 1'b1) begin
        fails++;
        $display("FAIL imm_valid[%0d]: got accepted=%b valid=%b expected 1/1", i, ok, bus32.out_valid);
      end
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL imm_sb[%0d]: got empty scoreboard expected an entry", i);
      end else begin
        e = sb.pop_front();
        if ({bus32.out_pc, bus32.out_imm, bus32.out_rd, bus32.out_rd_we, bus32.out_is_load, bus32.out_illegal}
            !== {e.pc[31:0], e.imm[31:0], e.rd, e.rd_we, e.is_load, e.illegal}) begin
          fails++;
          $display("FAIL imm[%0d]: got pc=%h imm=%h rd=%0d we=%b ld=%b il=%b expected pc=%h imm=%h rd=%0d we=%b ld=%b il=%b",
                   i, bus32.out_pc, bus32.out_imm, bus32.out_rd, bus32.out_rd_we, bus32.out_is_load,
                   bus32.out_illegal, e.pc[31:0], e.imm[31:0], e.rd, e.rd_we, e.is_load, e.illegal);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in_pc    = 32'h4000 + 32'(4 * i);
      bus32.in_instr = (32'(i) << 20) | (32'(i + 1) << 7) | 32'h13; // addi x(i+1),x0,i
      sb.push_back(mk(64'h4000 + 64'(4 * i), 64'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0));
      #1;
      tests++;
      if (bus32.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus32.in_ready);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if ({bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd} !== {1'b1, e.pc[31:0], e.imm[31:0], e.rd}) begin
        fails++;
        $display("FAIL b2b[%0d]: got v=%b pc=%h imm=%h rd=%0d expected v=1 pc=%h imm=%h rd=%0d",
                 i, bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd, e.pc[31:0], e.imm[31:0], e.rd);
      end
    end
    bus32.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    exp_t e;
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1; bus32.in_pc = 32'h2000; bus32.in_instr = I_LW;
    sb.push_back(mk(64'h2000, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0));
    tick();
    e = sb.pop_front();
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_rd, bus32.out_is_load} !== {1'b1, e.pc[31:0], e.rd, e.is_load}) begin
      fails++;
      $display("FAIL lu_load: got v=%b pc=%h rd=%0d ld=%b expected v=1 pc=%h rd=%0d ld=1",
               bus32.out_valid, bus32.out_pc, bus32.out_rd, bus32.out_is_load, e.pc[31:0], e.rd);
    end
    bus32.in_pc = 32'h2004; bus32.in_instr = I_ADD;
    sb.push_back(mk(64'h2004, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0));
    #1;
    tests++;
    if (bus32.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL lu_in_ready: got %b expected 0", bus32.in_ready);
    end
    @(posedge clk); #1;
    exp_cnt32 = exp_cnt32 + 16'd1;
    tests++;
    if ({bus32.out_valid, cnt32} !== {1'b0, exp_cnt32}) begin
      fails++;
      $display("FAIL lu_bubble: got valid=%b cnt=%0d expected valid=0 cnt=%0d", bus32.out_valid, cnt32, exp_cnt32);
    end
    tick();
    e = sb.pop_front();
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_rd, bus32.out_rd_we} !== {1'b1, e.pc[31:0], e.rd, e.rd_we}) begin
      fails++;
      $display("FAIL lu_add: got v=%b pc=%h rd=%0d we=%b expected v=1 pc=%h rd=%0d we=1",
               bus32.out_valid, bus32.out_pc, bus32.out_rd, bus32.out_rd_we, e.pc[31:0], e.rd);
    end
    bus32.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_no_hazard();
    exp_t e;
    busnh.out_ready = 1'b1;
    busnh.in_valid = 1'b1; busnh.in_pc = 32'h5000; busnh.in_instr = I_LW;
    tick();
    busnh.in_pc = 32'h5004; busnh.in_instr = I_ADD;
    sb.push_back(mk(64'h5004, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0));
    #1;
    tests++;
    if (busnh.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL nh_in_ready: got %b expected 1", busnh.in_ready);
    end
    @(posedge clk); #1;
    busnh.in_valid = 1'b0;
    e = sb.pop_front();
    tests++;
    if ({busnh.out_valid, busnh.out_pc, busnh.out_rd, cntnh} !== {1'b1, e.pc[31:0], e.rd, 16'd0}) begin
      fails++;
      $display("FAIL nh_add: got v=%b pc=%h rd=%0d cnt=%0d expected v=1 pc=%h rd=%0d cnt=0",
               busnh.out_valid, busnh.out_pc, busnh.out_rd, cntnh, e.pc[31:0], e.rd);
    end
    // load to x0 followed by a reader of x0: no interlock on the hazard-enabled instance
    bus32.out_ready = 1'b1;
    bus32.in_valid = 1'b1; bus32.in_pc = 32'h5100; bus32.in_instr = I_LW0;
    tick();
    bus32.in_pc = 32'h5104; bus32.in_instr = I_ADD0;
    #1;
    tests++;
    if (bus32.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_in_ready: got %b expected 1", bus32.in_ready);
    end
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_rd, cnt32} !== {1'b1, 32'h5104, 5'd4, exp_cnt32}) begin
      fails++;
      $display("FAIL x0_add: got v=%b pc=%h rd=%0d cnt=%0d expected v=1 pc=5104 rd=4 cnt=%0d",
               bus32.out_valid, bus32.out_pc, bus32.out_rd, cnt32, exp_cnt32);
    end
    tick();
  endtask

  task automatic test_xlen64();
    logic [31:0] ins [3];
    exp_t e;
    ins = '{32'h800002B7, 32'h02109093, I_ADDI_M}; // lui x5,0x80000; slli x1,x1,33; addi x1,x0,-1
    sb.push_back(mk(64'h1_0000_0000, 64'hFFFFFFFF_80000000, 5'd5, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'h1_0000_0004, 64'd33, 5'd1, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk(64'h1_0000_0008, 64'hFFFFFFFF_FFFFFFFF, 5'd1, 1'b1, 1'b0, 1'b0));
    bus64.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus64.in_valid = 1'b1;
      bus64.in_pc    = 64'h1_0000_0000 + 64'(4 * i);
      bus64.in_instr = ins[i];
      tick();
      e = sb.pop_front();
      tests++;
      if ({bus64.out_valid, bus64.out_pc, bus64.out_imm, bus64.out_rd} !== {1'b1, e.pc, e.imm, e.rd}) begin
        fails++;
        $display("FAIL x64[%0d]: got v=%b pc=%h imm=%h rd=%0d expected v=1 pc=%h imm=%h rd=%0d",
                 i, bus64.out_valid, bus64.out_pc, bus64.out_imm, bus64.out_rd, e.pc, e.imm, e.rd);
      end
    end
    bus64.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    // hold under backpressure, then flush the held instruction
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_pc = 32'h3000; bus32.in_instr = I_ADDI_M;
    tick();
    bus32.in_pc = 32'h3004; bus32.in_instr = I_AUIPC;
    #1;
    tests++;
    if ({bus32.out_valid, bus32.in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL fl_busy: got valid=%b in_ready=%b expected 1/0", bus32.out_valid, bus32.in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_imm} !== {1'b1, 32'h3000, 32'hFFFFFFFF}) begin
      fails++;
      $display("FAIL fl_hold: got v=%b pc=%h imm=%h expected v=1 pc=3000 imm=ffffffff",
               bus32.out_valid, bus32.out_pc, bus32.out_imm);
    end
    flush32 = 1'b1;
    #1;
    tests++;
    if (bus32.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL fl_in_ready: got %b expected 0", bus32.in_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (bus32.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fl_kill: got valid=%b expected 0", bus32.out_valid);
    end
    flush32 = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    tick();
    // flush coinciding with a load-use: no bubble counted, input dropped that cycle
    bus32.in_valid = 1'b1; bus32.in_pc = 32'h3100; bus32.in_instr = I_LW;
    tick();
    bus32.in_pc = 32'h3104; bus32.in_instr = I_ADD; flush32 = 1'b1;
    tick();
    tests++;
    if ({bus32.out_valid, cnt32} !== {1'b0, exp_cnt32}) begin
      fails++;
      $display("FAIL fl_lu: got valid=%b cnt=%0d expected valid=0 cnt=%0d", bus32.out_valid, cnt32, exp_cnt32);
    end
    flush32 = 1'b0;
    tick();
    bus32.in_valid = 1'b0;
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_rd} !== {1'b1, 32'h3104, 5'd4}) begin
      fails++;
      $display("FAIL fl_retry: got v=%b pc=%h rd=%0d expected v=1 pc=3104 rd=4",
               bus32.out_valid, bus32.out_pc, bus32.out_rd);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bus32.out_ready = 1'b0;
    bus32.in_valid = 1'b1; bus32.in_pc = 32'h6000; bus32.in_instr = I_LW;
    tick();
    bus32.in_pc = 32'h6004; bus32.in_instr = I_ADD;
    tick();
    tests++;
    if ({bus32.out_valid, bus32.in_ready, cnt32} !== {1'b1, 1'b0, exp_cnt32}) begin
      fails++;
      $display("FAIL mid_stall: got v=%b in_ready=%b cnt=%0d expected v=1 in_ready=0 cnt=%0d",
               bus32.out_valid, bus32.in_ready, cnt32, exp_cnt32);
    end
    #2 reset = 1'b1;
    #1;
    exp_cnt32 = '0;
    tests++;
    if ({bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd, cnt32} !== '0) begin
      fails++;
      $display("FAIL async_reset: got v=%b pc=%h imm=%h rd=%0d cnt=%0d expected all zero before next edge",
               bus32.out_valid, bus32.out_pc, bus32.out_imm, bus32.out_rd, cnt32);
    end
    tests++;
    if (bus32.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_ready: got %b expected 1", bus32.in_ready);
    end
    bus32.in_valid = 1'b0;
    tick();
    reset = 1'b0;
    bus32.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_imm();
    test_back_to_back();
    test_load_use();
    test_no_hazard();
    test_xlen64();
    test_flush();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
